// File: rtl/data_buffer_arbiter_if.sv
// rtl/data_buffer_arbiter_if.sv - request, buffer and status signal bundle for data_buffer_arbiter
interface data_buffer_arbiter_if;
  logic       clear;
  logic       ahb_store;
  logic       ahb_get;
  logic [7:0] ahb_wdata;
  logic       rx_transfer_active;
  logic       tx_transfer_active;
  logic       rx_store;
  logic [7:0] rx_wdata;
  logic       tx_get;
  logic [6:0] buffer_occupancy;
  logic [7:0] buf_rdata;
  logic       buf_write;
  logic       buf_read;
  logic       buf_flush;
  logic [7:0] buf_wdata;
  logic       ahb_ack;
  logic       rx_ack;
  logic       tx_ack;
  logic [7:0] ahb_rdata;
  logic [7:0] tx_rdata;
  logic       rd_valid_ahb;
  logic       rd_valid_tx;
  logic       overflow;
  logic       underflow;
  logic [1:0] owner;

  modport slave (
    input  clear, ahb_store, ahb_get, ahb_wdata, rx_transfer_active, tx_transfer_active,
           rx_store, rx_wdata, tx_get, buffer_occupancy, buf_rdata,
    output buf_write, buf_read, buf_flush, buf_wdata, ahb_ack, rx_ack, tx_ack,
           ahb_rdata, tx_rdata, rd_valid_ahb, rd_valid_tx, overflow, underflow, owner
  );

  modport master (
    output clear, ahb_store, ahb_get, ahb_wdata, rx_transfer_active, tx_transfer_active,
           rx_store, rx_wdata, tx_get, buffer_occupancy, buf_rdata,
    input  buf_write, buf_read, buf_flush, buf_wdata, ahb_ack, rx_ack, tx_ack,
           ahb_rdata, tx_rdata, rd_valid_ahb, rd_valid_tx, overflow, underflow, owner
  );
endinterface

// File: rtl/data_buffer_arbiter.sv
// rtl/data_buffer_arbiter.sv - arbitrates AHB and USB access to a 64-byte data buffer
// Optional sticky overflow/underflow flags are enabled by defining ARB_ERROR_FLAGS_EN.
module data_buffer_arbiter (
  input logic                  clk,
  input logic                  n_rst,
  data_buffer_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AHB   = 2'd1,
    ST_USB   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_clear_pend, w_clear_pend_nxt;
  logic       w_usb_active, w_full, w_empty;
  logic       w_serve_usb, w_flush;
  logic       w_ahb_ack, w_rx_ack, w_tx_ack;
  logic       w_is_wr, w_is_rd, w_rd_for_ahb;
  logic [7:0] w_wdata;

  logic       r_buf_write, r_buf_read, r_buf_flush;
  logic [7:0] r_buf_wdata;
  logic       r_ahb_ack, r_rx_ack, r_tx_ack;
  logic       r_rd_ahb_s1, r_rd_tx_s1, r_rd_drop_s1;
  logic       r_rd_valid_ahb, r_rd_valid_tx, r_rd_drop_s2;
  logic [7:0] r_ahb_rdata, r_tx_rdata;
  logic [7:0] w_rd_byte, w_ahb_rdata, w_tx_rdata;

  assign w_usb_active = bus.rx_transfer_active | bus.tx_transfer_active;
  assign w_full       = (bus.buffer_occupancy >= 7'd64);
  assign w_empty      = (bus.buffer_occupancy == 7'd0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= ST_IDLE;
      r_clear_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clear_pend <= w_clear_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_clear_pend_nxt = r_clear_pend;
    w_serve_usb      = 1'b0;
    w_flush          = 1'b0;
    w_ahb_ack        = 1'b0;
    w_rx_ack         = 1'b0;
    w_tx_ack         = 1'b0;
    w_is_wr          = 1'b0;
    w_is_rd          = 1'b0;
    w_rd_for_ahb     = 1'b0;
    w_wdata          = 8'h00;
    case (r_state)
      ST_IDLE: begin
        // USB wins over everything; a clear arriving alongside it waits in the latch
        if (w_usb_active) begin
          w_state_nxt      = ST_USB;
          w_clear_pend_nxt = r_clear_pend | bus.clear;
          w_serve_usb      = 1'b1;
        end else if (bus.clear || r_clear_pend) begin
          w_state_nxt      = ST_FLUSH;
          w_clear_pend_nxt = 1'b0;
          w_flush          = 1'b1;
        end else if (bus.ahb_store) begin
          w_state_nxt = ST_AHB;
          w_ahb_ack   = 1'b1;
          w_is_wr     = 1'b1;
          w_wdata     = bus.ahb_wdata;
        end else if (bus.ahb_get) begin
          w_state_nxt  = ST_AHB;
          w_ahb_ack    = 1'b1;
          w_is_rd      = 1'b1;
          w_rd_for_ahb = 1'b1;
        end
      end
      ST_AHB: begin
        w_state_nxt      = ST_IDLE;
        w_clear_pend_nxt = r_clear_pend | bus.clear;
      end
      ST_USB: begin
        w_serve_usb      = 1'b1;
        w_clear_pend_nxt = r_clear_pend | bus.clear;
        if (!w_usb_active) w_state_nxt = ST_IDLE;
      end
      ST_FLUSH: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_serve_usb) begin
      if (bus.rx_store) begin
        w_rx_ack = 1'b1;
        w_is_wr  = 1'b1;
        w_wdata  = bus.rx_wdata;
      end else if (bus.tx_get) begin
        w_tx_ack = 1'b1;
        w_is_rd  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_buf_write    <= 1'b0;
      r_buf_read     <= 1'b0;
      r_buf_flush    <= 1'b0;
      r_buf_wdata    <= 8'h00;
      r_ahb_ack      <= 1'b0;
      r_rx_ack       <= 1'b0;
      r_tx_ack       <= 1'b0;
      r_rd_ahb_s1    <= 1'b0;
      r_rd_tx_s1     <= 1'b0;
      r_rd_drop_s1   <= 1'b0;
      r_rd_valid_ahb <= 1'b0;
      r_rd_valid_tx  <= 1'b0;
      r_rd_drop_s2   <= 1'b0;
      r_ahb_rdata    <= 8'h00;
      r_tx_rdata     <= 8'h00;
    end else begin
      r_buf_write <= w_is_wr & ~w_full;
      r_buf_read  <= w_is_rd & ~w_empty;
      r_buf_flush <= w_flush;
      if (w_is_wr && !w_full) r_buf_wdata <= w_wdata;
      r_ahb_ack      <= w_ahb_ack;
      r_rx_ack       <= w_rx_ack;
      r_tx_ack       <= w_tx_ack;
      r_rd_ahb_s1    <= w_rd_for_ahb;
      r_rd_tx_s1     <= w_tx_ack;
      r_rd_drop_s1   <= w_is_rd & w_empty;
      r_rd_valid_ahb <= r_rd_ahb_s1;
      r_rd_valid_tx  <= r_rd_tx_s1;
      r_rd_drop_s2   <= r_rd_drop_s1;
      if (r_rd_valid_ahb) r_ahb_rdata <= w_ahb_rdata;
      if (r_rd_valid_tx)  r_tx_rdata  <= w_tx_rdata;
    end
  end

  // buf_rdata arrives the cycle after buf_read, so it is passed straight through and held afterwards
  assign w_rd_byte   = r_rd_drop_s2 ? 8'h00 : bus.buf_rdata;
  assign w_ahb_rdata = r_rd_valid_ahb ? w_rd_byte : r_ahb_rdata;
  assign w_tx_rdata  = r_rd_valid_tx  ? w_rd_byte : r_tx_rdata;

`ifdef ARB_ERROR_FLAGS_EN
  logic r_overflow, r_underflow;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (w_flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_is_wr && w_full)  r_overflow  <= 1'b1;
      if (w_is_rd && w_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.buf_write    = r_buf_write;
  assign bus.buf_read     = r_buf_read;
  assign bus.buf_flush    = r_buf_flush;
  assign bus.buf_wdata    = r_buf_wdata;
  assign bus.ahb_ack      = r_ahb_ack;
  assign bus.rx_ack       = r_rx_ack;
  assign bus.tx_ack       = r_tx_ack;
  assign bus.ahb_rdata    = w_ahb_rdata;
  assign bus.tx_rdata     = w_tx_rdata;
  assign bus.rd_valid_ahb = r_rd_valid_ahb;
  assign bus.rd_valid_tx  = r_rd_valid_tx;
  assign bus.owner        = r_state;
endmodule

// File: tb/tb_data_buffer_arbiter.sv
// tb/tb_data_buffer_arbiter.sv - scoreboard bench for data_buffer_arbiter
module tb_data_buffer_arbiter;
  logic clk = 1'b0;
  logic n_rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

`ifdef ARB_ERROR_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  data_buffer_arbiter_if bus ();
  data_buffer_arbiter dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // event kinds: 0 ahb_ack 1 rx_ack 2 tx_ack 3 buf_write 4 buf_read 5 buf_flush 6 ahb rdata 7 tx rdata
  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] val;
  } ev_t;
  ev_t exp_q[$];

  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;
  int m_k = 0;
  int tb_rd_k = 0;

  function automatic logic [7:0] rd_val(input int k);
    return 8'(k * 37 + 11);
  endfunction

  // buffer memory stand-in: each real read returns the next value of a known sequence
  always @(posedge clk) begin
    if (bus.buf_read) begin
      bus.buf_rdata <= rd_val(tb_rd_k);
      tb_rd_k       <= tb_rd_k + 1;
    end
  end

  function automatic string kname(input int k);
    case (k)
      0: return "ahb_ack";
      1: return "rx_ack";
      2: return "tx_ack";
      3: return "buf_write";
      4: return "buf_read";
      5: return "buf_flush";
      6: return "ahb_rdata";
      default: return "tx_rdata";
    endcase
  endfunction

  task automatic push(input int k, input int c, input logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic model_write(input int who, input logic [7:0] d, input int occ, input int c);
    push(who, c + 1, 8'h00);
    if (occ < 64) push(3, c + 1, d);
    else m_ovf = 1'b1;
  endtask

  task automatic model_read(input int who, input int occ, input int c);
    int rk;
    rk = (who == 0) ? 6 : 7;
    push(who, c + 1, 8'h00);
    if (occ > 0) begin
      push(4, c + 1, 8'h00);
      push(rk, c + 2, rd_val(m_k));
      m_k++;
    end else begin
      push(rk, c + 2, 8'h00);
      m_udf = 1'b1;
    end
  endtask

  task automatic model_flush(input int c);
    push(5, c + 1, 8'h00);
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic obs(input int k, input logic hit, input logic [7:0] v);
    int j;
    j = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].kind == k) begin
        j = i;
        break;
      end
    end
    if (hit) begin
      n_tests++;
      if (j < 0) begin
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d value %02h, required no event", kname(k), cyc, v);
      end else begin
        if (exp_q[j].cyc != cyc || exp_q[j].val != v) begin
          n_fail++;
          $display("FAIL %s: got cycle %0d value %02h, required cycle %0d value %02h",
                   kname(k), cyc, v, exp_q[j].cyc, exp_q[j].val);
        end
        exp_q.delete(j);
      end
    end else if (j >= 0 && exp_q[j].cyc <= cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no event at cycle %0d, required value %02h at cycle %0d",
               kname(k), cyc, exp_q[j].val, exp_q[j].cyc);
      exp_q.delete(j);
    end
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      obs(0, bus.ahb_ack, 8'h00);
      obs(1, bus.rx_ack, 8'h00);
      obs(2, bus.tx_ack, 8'h00);
      obs(3, bus.buf_write, bus.buf_wdata);
      obs(4, bus.buf_read, 8'h00);
      obs(5, bus.buf_flush, 8'h00);
      obs(6, bus.rd_valid_ahb, bus.ahb_rdata);
      obs(7, bus.rd_valid_tx, bus.tx_rdata);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_flags();
    chk("overflow", int'(bus.overflow), FLAGS_EN ? int'(m_ovf) : 0);
    chk("underflow", int'(bus.underflow), FLAGS_EN ? int'(m_udf) : 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_owner"}, int'(bus.owner), 0);
    chk({tag, "_buf_write"}, int'(bus.buf_write), 0);
    chk({tag, "_buf_read"}, int'(bus.buf_read), 0);
    chk({tag, "_buf_flush"}, int'(bus.buf_flush), 0);
    chk({tag, "_buf_wdata"}, int'(bus.buf_wdata), 0);
    chk({tag, "_acks"}, int'({bus.ahb_ack, bus.rx_ack, bus.tx_ack}), 0);
    chk({tag, "_rd_valid"}, int'({bus.rd_valid_ahb, bus.rd_valid_tx}), 0);
    chk({tag, "_ahb_rdata"}, int'(bus.ahb_rdata), 0);
    chk({tag, "_tx_rdata"}, int'(bus.tx_rdata), 0);
    chk({tag, "_flags"}, int'({bus.overflow, bus.underflow}), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.clear              = 1'b0;
    bus.ahb_store          = 1'b0;
    bus.ahb_get            = 1'b0;
    bus.ahb_wdata          = 8'h00;
    bus.rx_transfer_active = 1'b0;
    bus.tx_transfer_active = 1'b0;
    bus.rx_store           = 1'b0;
    bus.rx_wdata           = 8'h00;
    bus.tx_get             = 1'b0;
  endtask

  task automatic idle(input int n);
    clear_reqs();
    repeat (n) tick();
  endtask

  function automatic int rand_occ();
    int r;
    r = int'($urandom_range(0, 3));
    if (r == 0) return 0;
    if (r == 1) return 64;
    return int'($urandom_range(1, 63));
  endfunction

  // kind: 0 store, 1 get, 2 store and get together (store wins)
  task automatic ahb_txn(input int kind, input int occ, input logic [7:0] d);
    bus.ahb_store        = (kind != 1);
    bus.ahb_get          = (kind != 0);
    bus.ahb_wdata        = d;
    bus.buffer_occupancy = 7'(occ);
    if (kind != 1) model_write(0, d, occ, cyc);
    else model_read(0, occ, cyc);
    tick();
    chk("owner_ahb", int'(bus.owner), 1);
    idle(3);
    chk_flags();
  endtask

  task automatic flush_txn(input bit with_store, input int occ, input logic [7:0] d);
    bus.clear            = 1'b1;
    bus.ahb_store        = with_store;
    bus.ahb_wdata        = d;
    bus.buffer_occupancy = 7'(occ);
    model_flush(cyc);
    tick();
    bus.clear = 1'b0;
    chk("owner_flush", int'(bus.owner), 3);
    tick();
    if (with_store) begin
      model_write(0, d, occ, cyc);
      tick();
    end
    idle(3);
    chk_flags();
  endtask

  // op: 0 random rx_store/tx_get, 1 rx_store every cycle, 2 tx_get every cycle
  task automatic usb_txn(input int len, input int op, input int occ_fix, input bit with_get, input bit with_clear);
    int clr_at, o;
    bit rx_a, st, gt;
    clr_at = with_clear ? int'($urandom_range(0, len - 1)) : -1;
    rx_a   = ($urandom_range(0, 1) == 1);
    for (int i = 0; i < len; i++) begin
      st = (op == 1) || (op == 0 && $urandom_range(0, 1) == 1);
      gt = (op == 2) || (op == 0 && $urandom_range(0, 1) == 1);
      o  = (occ_fix >= 0) ? occ_fix : rand_occ();
      bus.rx_transfer_active = rx_a;
      bus.tx_transfer_active = !rx_a || ($urandom_range(0, 3) == 0);
      bus.rx_store           = st;
      bus.rx_wdata           = 8'($urandom);
      bus.tx_get             = gt;
      bus.buffer_occupancy   = 7'(o);
      bus.clear              = (i == clr_at);
      bus.ahb_get            = with_get;
      if (st) model_write(1, bus.rx_wdata, o, cyc);
      else if (gt) model_read(2, o, cyc);
      tick();
      if (i == 0) chk("owner_usb", int'(bus.owner), 2);
    end
    o = (occ_fix >= 0) ? occ_fix : rand_occ();
    clear_reqs();
    bus.ahb_get          = with_get;
    bus.buffer_occupancy = 7'(o);
    tick();
    if (with_clear) begin
      model_flush(cyc);
      tick();
      tick();
    end
    if (with_get) begin
      model_read(0, o, cyc);
      tick();
    end
    idle(3);
    chk_flags();
  endtask

  initial begin
    clear_reqs();
    bus.buffer_occupancy = 7'd0;
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    n_rst = 1'b1;
    tick();
    tick();

    ahb_txn(0, 3, 8'hA5);
    usb_txn(3, 2, 5, 1'b1, 1'b0);
    usb_txn(1, 1, 64, 1'b0, 1'b0);
    usb_txn(1, 2, 0, 1'b0, 1'b0);
    usb_txn(4, 1, 64, 1'b0, 1'b1);
    ahb_txn(1, 0, 8'h00);
    flush_txn(1'b1, 10, 8'h3C);
    ahb_txn(2, 20, 8'h77);
    ahb_txn(1, 64, 8'h00);
    usb_txn(2, 0, -1, 1'b1, 1'b1);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 4))
        0: ahb_txn(0, rand_occ(), 8'($urandom));
        1: ahb_txn(1, rand_occ(), 8'h00);
        2: ahb_txn(2, rand_occ(), 8'($urandom));
        3: usb_txn(int'($urandom_range(1, 6)), 0, -1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        default: flush_txn($urandom_range(0, 1) == 1, rand_occ(), 8'($urandom));
      endcase
    end
    chk("queue_drain", exp_q.size(), 0);

    bus.rx_transfer_active = 1'b1;
    bus.rx_store           = 1'b1;
    bus.rx_wdata           = 8'h5C;
    bus.buffer_occupancy   = 7'd10;
    bus.clear              = 1'b1;
    model_write(1, 8'h5C, 10, cyc);
    tick();
    bus.clear = 1'b0;
    chk("owner_pre_reset", int'(bus.owner), 2);
    chk("wdata_pre_reset", int'(bus.buf_wdata), 8'h5C);
    @(negedge clk);
    #1;
    n_rst = 1'b0;
    clear_reqs();
    #1;
    chk_zero("async_reset");
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(8);
    chk("owner_after_reset", int'(bus.owner), 0);
    chk("queue_drain_final", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
